dhm_sleep_ctrl: RTL and testbench
=================================

# dhm_sleep_ctrl

Sequencer that produces the `sleep` / `sleep_n` pair consumed by `dhm_buf`, which fans the pair out as the local sleep signals. It converts a single level request into a staged, glitch-free power-down and power-up sequence, asserts the two polarities at different times to limit rush current, and reports settled status to the requester. All outputs are registered, so `dhm_buf` sees clean flop outputs.

## Interface

Parameters:
- `ENTER_DLY`, default 4: cycles spent in the enter stage (`sleep`=1, `sleep_n`=1) before `sleep_n` drops; legal range 1..2^CNT_W-1.
- `EXIT_DLY`, default 4: cycles spent in the exit stage (`sleep`=1, `sleep_n`=1) before `sleep` drops; legal range 1..2^CNT_W-1.
- `CNT_W`, default 4: width of the internal delay counter.

Ports:
- `clk`  in  1  single clock.
- `rst`  in  1  reset; synchronous and active-high.
- `sleep_req`  in  1  level request; 1 = go to sleep, 0 = stay or return awake.
- `sleep`  out  1  to `dhm_buf.sleep`; active-high sleep.
- `sleep_n`  out  1  to `dhm_buf.sleep_n`; active-low sleep.
- `sleep_ack`  out  1  1 only while fully asleep (ASLEEP).
- `awake`  out  1  1 only while fully awake (AWAKE).
- `sleep_cnt`  out  8  count of completed sleep entries; saturates at 255.

## Operation

- FSM has four states:
  - AWAKE: `sleep`=0, `sleep_n`=1, `awake`=1, `sleep_ack`=0.
  - ENTER: `sleep`=1, `sleep_n`=1, `awake`=0, `sleep_ack`=0.
  - ASLEEP: `sleep`=1, `sleep_n`=0, `awake`=0, `sleep_ack`=1.
  - EXIT: `sleep`=1, `sleep_n`=1, `awake`=0, `sleep_ack`=0.
- Transitions:
  - AWAKE → ENTER when `sleep_req`=1. Counter loads ENTER_DLY-1.
  - ENTER → ASLEEP when the counter reaches 0; otherwise the counter decrements.
  - ASLEEP → EXIT when `sleep_req`=0. Counter loads EXIT_DLY-1.
  - EXIT → AWAKE when the counter reaches 0; otherwise the counter decrements.
- ENTER and EXIT are atomic. `sleep_req` is sampled only in AWAKE and ASLEEP; toggling it mid-sequence has no effect until that sequence completes.
- Ordering invariant: `sleep` always rises before `sleep_n` falls, and `sleep_n` always rises before `sleep` falls. The combination `sleep`=0 with `sleep_n`=0 must never occur, including at and after reset.
- `sleep_cnt` increments by 1 on every ENTER → ASLEEP transition and holds at 255.
- Outputs are decoded from registered state, or are registered themselves; there are no combinational paths from `sleep_req` to any output.

## Timing

- Reset (`rst`=1 at an edge): next state is AWAKE, counter is 0, `sleep_cnt` is 0.
  - Output values after reset: `sleep`=0, `sleep_n`=1, `awake`=1, `sleep_ack`=0.
- Reset mid-sequence, from ENTER, ASLEEP or EXIT: the block moves directly to AWAKE values on the next edge. This is the only permitted direct ASLEEP → AWAKE step.
- Enter latency: `sleep_req` sampled 1 at edge N in AWAKE.
  - `sleep`=1 and `awake`=0 from edge N.
  - `sleep_n`=0 and `sleep_ack`=1 from edge N+ENTER_DLY.
  - `sleep_cnt` updates at the same edge, N+ENTER_DLY.
- Exit latency: `sleep_req` sampled 0 at edge M in ASLEEP.
  - `sleep_n`=1 and `sleep_ack`=0 from edge M.
  - `sleep`=0 and `awake`=1 from edge M+EXIT_DLY.
- Back-to-back requests: if `sleep_req` is still 1 when AWAKE is re-entered, ENTER starts on the next edge. AWAKE therefore lasts a minimum of 1 cycle; ASLEEP likewise lasts a minimum of 1 cycle.
- With ENTER_DLY=1 and EXIT_DLY=1, each of ENTER and EXIT lasts exactly 1 cycle.

## Test plan

- Reset check: hold `rst` for 2 cycles → `sleep`=0, `sleep_n`=1, `awake`=1, `sleep_ack`=0, `sleep_cnt`=0.
- Enter, with ENTER_DLY=4: raise `sleep_req` at edge 10 →
  - `sleep`=1 from edge 10;
  - `sleep_n`=0, `sleep_ack`=1 and `sleep_cnt`=1 from edge 14.
- Exit, with EXIT_DLY=4: drop `sleep_req` at edge 20 →
  - `sleep_n`=1 and `sleep_ack`=0 from edge 20;
  - `sleep`=0 and `awake`=1 from edge 24.
- Atomicity: pulse `sleep_req` high for 1 cycle → the full ENTER, then ASLEEP for 1 cycle, then the full EXIT; total `awake`-low time is ENTER_DLY+1+EXIT_DLY cycles.
- Reset during ENTER (edge 12) and during ASLEEP → AWAKE values on the next edge, and `sleep_cnt` is cleared to 0.
- Saturation and invariant:
  - Run 300 sleep/wake cycles → `sleep_cnt` stays at 255.
  - A monitor checks every cycle that `sleep`=0 with `sleep_n`=0 never occurs.

Source files
------------

// File: rtl/dhm_sleep_ctrl.sv
// Staged sleep sequencer driving the dhm_buf sleep/sleep_n pair.
// The two polarities change on separate edges so sleep=0 with sleep_n=0 never occurs.
module dhm_sleep_ctrl #(
    parameter int unsigned ENTER_DLY = 4,
    parameter int unsigned EXIT_DLY  = 4,
    parameter int unsigned CNT_W     = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sleep_req,
    output logic       sleep,
    output logic       sleep_n,
    output logic       sleep_ack,
    output logic       awake,
    output logic [7:0] sleep_cnt
);

    typedef enum logic [1:0] {
        ST_AWAKE,
        ST_ENTER,
        ST_ASLEEP,
        ST_EXIT
    } state_t;

    localparam logic [CNT_W-1:0] ENTER_LOAD = CNT_W'(ENTER_DLY - 1);
    localparam logic [CNT_W-1:0] EXIT_LOAD  = CNT_W'(EXIT_DLY - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;

    // Outputs are updated alongside the state so each one is a plain flop.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_AWAKE;
            cnt       <= '0;
            sleep_cnt <= '0;
            sleep     <= 1'b0;
            sleep_n   <= 1'b1;
            awake     <= 1'b1;
            sleep_ack <= 1'b0;
        end else begin
            case (state)
                ST_AWAKE: begin
                    if (sleep_req) begin
                        state <= ST_ENTER;
                        cnt   <= ENTER_LOAD;
                        sleep <= 1'b1;
                        awake <= 1'b0;
                    end
                end
                ST_ENTER: begin
                    if (cnt == '0) begin
                        state     <= ST_ASLEEP;
                        sleep_n   <= 1'b0;
                        sleep_ack <= 1'b1;
                        if (sleep_cnt != '1)
                            sleep_cnt <= sleep_cnt + 8'd1;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_ASLEEP: begin
                    if (!sleep_req) begin
                        state     <= ST_EXIT;
                        cnt       <= EXIT_LOAD;
                        sleep_n   <= 1'b1;
                        sleep_ack <= 1'b0;
                    end
                end
                ST_EXIT: begin
                    if (cnt == '0) begin
                        state <= ST_AWAKE;
                        sleep <= 1'b0;
                        awake <= 1'b1;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: begin
                    state     <= ST_AWAKE;
                    cnt       <= '0;
                    sleep     <= 1'b0;
                    sleep_n   <= 1'b1;
                    awake     <= 1'b1;
                    sleep_ack <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dhm_sleep_ctrl.sv
// Directed bench for dhm_sleep_ctrl: default 4/4 delays plus a 1/1 instance.
module tb_dhm_sleep_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sleep_req = 1'b0;
    logic       sleep, sleep_n, sleep_ack, awake;
    logic [7:0] sleep_cnt;
    logic       sleep1, sleep_n1, sleep_ack1, awake1;
    logic [7:0] sleep_cnt1;

    int n_cmp = 0;
    int n_err = 0;
    bit mon_en = 1'b0;

    always #5 clk = ~clk;

    dhm_sleep_ctrl #(.ENTER_DLY(4), .EXIT_DLY(4), .CNT_W(4)) dut (
        .clk(clk), .rst(rst), .sleep_req(sleep_req),
        .sleep(sleep), .sleep_n(sleep_n), .sleep_ack(sleep_ack),
        .awake(awake), .sleep_cnt(sleep_cnt)
    );

    dhm_sleep_ctrl #(.ENTER_DLY(1), .EXIT_DLY(1), .CNT_W(4)) dut1 (
        .clk(clk), .rst(rst), .sleep_req(sleep_req),
        .sleep(sleep1), .sleep_n(sleep_n1), .sleep_ack(sleep_ack1),
        .awake(awake1), .sleep_cnt(sleep_cnt1)
    );

    always @(negedge clk) begin
        if (mon_en) begin
            n_cmp++;
            if (sleep !== 1'b1 && sleep_n !== 1'b1) begin
                n_err++;
                $display("FAIL invariant dut: sleep=%b sleep_n=%b required not both 0", sleep, sleep_n);
            end
            n_cmp++;
            if (sleep1 !== 1'b1 && sleep_n1 !== 1'b1) begin
                n_err++;
                $display("FAIL invariant dut1: sleep=%b sleep_n=%b required not both 0", sleep1, sleep_n1);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        sleep_req = 1'b0;
        tick();
        mon_en = 1'b1;
        tick();
        n_cmp++;
        if ({sleep, sleep_n, awake, sleep_ack} !== 4'b0110) begin
            n_err++;
            $display("FAIL reset_outputs: got %b required 0110", {sleep, sleep_n, awake, sleep_ack});
        end
        n_cmp++;
        if (sleep_cnt !== 8'd0) begin
            n_err++;
            $display("FAIL reset_cnt: got %0d required 0", sleep_cnt);
        end
        n_cmp++;
        if ({sleep1, sleep_n1, awake1, sleep_ack1} !== 4'b0110) begin
            n_err++;
            $display("FAIL reset_outputs1: got %b required 0110", {sleep1, sleep_n1, awake1, sleep_ack1});
        end
        rst = 1'b0;
        tick();
        n_cmp++;
        if (awake !== 1'b1 || sleep !== 1'b0) begin
            n_err++;
            $display("FAIL reset_hold: awake=%b sleep=%b required 1 0", awake, sleep);
        end
    endtask

    task automatic test_enter();
        sleep_req = 1'b1;
        tick();
        n_cmp++;
        if ({sleep, sleep_n, awake, sleep_ack} !== 4'b1100) begin
            n_err++;
            $display("FAIL enter_edge0: got %b required 1100", {sleep, sleep_n, awake, sleep_ack});
        end
        for (int i = 1; i < 4; i++) begin
            tick();
            n_cmp++;
            if ({sleep, sleep_n, sleep_ack} !== 3'b110) begin
                n_err++;
                $display("FAIL enter_stage%0d: got %b required 110", i, {sleep, sleep_n, sleep_ack});
            end
        end
        tick();
        n_cmp++;
        if ({sleep, sleep_n, awake, sleep_ack} !== 4'b1001) begin
            n_err++;
            $display("FAIL enter_asleep: got %b required 1001", {sleep, sleep_n, awake, sleep_ack});
        end
        n_cmp++;
        if (sleep_cnt !== 8'd1) begin
            n_err++;
            $display("FAIL enter_cnt: got %0d required 1", sleep_cnt);
        end
    endtask

    task automatic test_exit();
        tick();
        tick();
        sleep_req = 1'b0;
        tick();
        n_cmp++;
        if ({sleep, sleep_n, awake, sleep_ack} !== 4'b1100) begin
            n_err++;
            $display("FAIL exit_edge0: got %b required 1100", {sleep, sleep_n, awake, sleep_ack});
        end
        for (int i = 1; i < 4; i++) begin
            tick();
            n_cmp++;
            if ({sleep, awake} !== 2'b10) begin
                n_err++;
                $display("FAIL exit_stage%0d: got %b required 10", i, {sleep, awake});
            end
        end
        tick();
        n_cmp++;
        if ({sleep, sleep_n, awake, sleep_ack} !== 4'b0110) begin
            n_err++;
            $display("FAIL exit_awake: got %b required 0110", {sleep, sleep_n, awake, sleep_ack});
        end
    endtask

    task automatic test_atomic();
        int low;
        int guard;
        sleep_req = 1'b1;
        tick();
        sleep_req = 1'b0;
        low = (awake === 1'b0) ? 1 : 0;
        guard = 0;
        while (awake !== 1'b1 && guard < 40) begin
            tick();
            guard++;
            if (awake === 1'b0) low++;
        end
        n_cmp++;
        if (low != 9) begin
            n_err++;
            $display("FAIL atomic_low_cycles: got %0d required 9", low);
        end
        n_cmp++;
        if (sleep_cnt !== 8'd2) begin
            n_err++;
            $display("FAIL atomic_cnt: got %0d required 2", sleep_cnt);
        end
    endtask

    task automatic test_back_to_back();
        sleep_req = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        n_cmp++;
        if (sleep_ack !== 1'b1 || sleep_cnt !== 8'd3) begin
            n_err++;
            $display("FAIL b2b_first: ack=%b cnt=%0d required 1 3", sleep_ack, sleep_cnt);
        end
        sleep_req = 1'b0;
        tick();
        sleep_req = 1'b1;
        for (int i = 1; i < 4; i++) begin
            tick();
            n_cmp++;
            if ({sleep, sleep_ack, awake} !== 3'b100) begin
                n_err++;
                $display("FAIL b2b_exit%0d: got %b required 100", i, {sleep, sleep_ack, awake});
            end
        end
        tick();
        n_cmp++;
        if ({sleep, awake} !== 2'b01) begin
            n_err++;
            $display("FAIL b2b_awake: got %b required 01", {sleep, awake});
        end
        tick();
        n_cmp++;
        if ({sleep, awake} !== 2'b10) begin
            n_err++;
            $display("FAIL b2b_reenter: got %b required 10", {sleep, awake});
        end
        for (int i = 0; i < 4; i++) tick();
        n_cmp++;
        if (sleep_ack !== 1'b1 || sleep_cnt !== 8'd4) begin
            n_err++;
            $display("FAIL b2b_second: ack=%b cnt=%0d required 1 4", sleep_ack, sleep_cnt);
        end
        sleep_req = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        n_cmp++;
        if (awake !== 1'b1) begin
            n_err++;
            $display("FAIL b2b_return: awake=%b required 1", awake);
        end
    endtask

    task automatic test_reset_mid();
        sleep_req = 1'b1;
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        n_cmp++;
        if ({sleep, sleep_n, awake, sleep_ack, sleep_cnt} !== {4'b0110, 8'd0}) begin
            n_err++;
            $display("FAIL rst_enter: got %b/%0d required 0110/0", {sleep, sleep_n, awake, sleep_ack}, sleep_cnt);
        end
        sleep_req = 1'b0;
        rst = 1'b0;
        tick();
        sleep_req = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        n_cmp++;
        if (sleep_ack !== 1'b1 || sleep_cnt !== 8'd1) begin
            n_err++;
            $display("FAIL rst_reasleep: ack=%b cnt=%0d required 1 1", sleep_ack, sleep_cnt);
        end
        rst = 1'b1;
        sleep_req = 1'b0;
        tick();
        n_cmp++;
        if ({sleep, sleep_n, awake, sleep_ack, sleep_cnt} !== {4'b0110, 8'd0}) begin
            n_err++;
            $display("FAIL rst_asleep: got %b/%0d required 0110/0", {sleep, sleep_n, awake, sleep_ack}, sleep_cnt);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_saturate();
        int guard;
        bit timed_out = 1'b0;
        for (int n = 0; n < 300 && !timed_out; n++) begin
            sleep_req = 1'b1;
            guard = 0;
            do begin tick(); guard++; end while (sleep_ack !== 1'b1 && guard < 20);
            if (sleep_ack !== 1'b1) timed_out = 1'b1;
            sleep_req = 1'b0;
            guard = 0;
            do begin tick(); guard++; end while (awake !== 1'b1 && guard < 20);
            if (awake !== 1'b1) timed_out = 1'b1;
        end
        n_cmp++;
        if (timed_out) begin
            n_err++;
            $display("FAIL sat_timeout: got timeout required handshake within 20 cycles");
        end
        n_cmp++;
        if (sleep_cnt !== 8'd255) begin
            n_err++;
            $display("FAIL sat_cnt: got %0d required 255", sleep_cnt);
        end
        n_cmp++;
        if (sleep_cnt1 !== 8'd255) begin
            n_err++;
            $display("FAIL sat_cnt1: got %0d required 255", sleep_cnt1);
        end
    endtask

    task automatic test_min_delay();
        sleep_req = 1'b1;
        tick();
        n_cmp++;
        if ({sleep1, sleep_n1, awake1, sleep_ack1} !== 4'b1100) begin
            n_err++;
            $display("FAIL min_enter: got %b required 1100", {sleep1, sleep_n1, awake1, sleep_ack1});
        end
        tick();
        n_cmp++;
        if ({sleep1, sleep_n1, awake1, sleep_ack1} !== 4'b1001) begin
            n_err++;
            $display("FAIL min_asleep: got %b required 1001", {sleep1, sleep_n1, awake1, sleep_ack1});
        end
        sleep_req = 1'b0;
        tick();
        n_cmp++;
        if ({sleep1, sleep_n1, awake1, sleep_ack1} !== 4'b1100) begin
            n_err++;
            $display("FAIL min_exit: got %b required 1100", {sleep1, sleep_n1, awake1, sleep_ack1});
        end
        tick();
        n_cmp++;
        if ({sleep1, sleep_n1, awake1, sleep_ack1} !== 4'b0110) begin
            n_err++;
            $display("FAIL min_awake: got %b required 0110", {sleep1, sleep_n1, awake1, sleep_ack1});
        end
        for (int i = 0; i < 8; i++) tick();
    endtask

    initial begin
        test_reset();
        test_enter();
        test_exit();
        test_atomic();
        test_back_to_back();
        test_reset_mid();
        test_saturate();
        test_min_delay();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
